// File: rtl/chip_run_ctrl_pkg.sv
// chip_ctrl_pkg: shared types and constants for the chip tester run controller.
//   state_e  : controller FSM states (IDLE, START, WAIT, DONE)
//   CNT_W    : width of the run/pass tallies
//   CNT_MAX  : saturation value of the tallies
//   sat_inc  : saturating increment used by both tallies
package chip_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = (v == CNT_MAX) ? v : CNT_W'(v + 1'b1);
    return r;
  endfunction

endpackage

// File: rtl/chip_run_ctrl_debounce.sv
// button_debounce: conditions the raw asynchronous push button.
//   Two-flop synchronizer, then a stability counter: the debounced level
//   flips only after DEBOUNCE_CYCLES consecutive synchronized samples differ
//   from it. A registered one-cycle press pulse accompanies each 0->1 flip.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   btn_raw in  raw push button (asynchronous)
//   press   out one-cycle pulse on a debounced rising edge
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the current level restarts the count, so only
  // an unbroken run of DEBOUNCE_CYCLES differing samples changes the level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/chip_run_ctrl.sv
// chip_run_ctrl: front-end controller for one chip tester socket.
//   Debounces the run button, pulses Start to the tester, waits for a Done
//   rising edge (or the watchdog), latches pass/fail LEDs and keeps
//   saturating run/pass tallies. All outputs are registered.
// Build option:
//   CHIP_RUN_CTRL_TIMEOUT_EN defined   -> watchdog present, fires after
//                                         TIMEOUT_CYCLES cycles of a run.
//   CHIP_RUN_CTRL_TIMEOUT_EN undefined -> no watchdog, Timeout tied low.
// Ports:
//   Clk        in   system clock
//   Reset      in   asynchronous active-high reset
//   Run_btn    in   raw push button
//   Done       in   tester completion flag
//   RSLT       in   tester verdict (1 = pass), valid when Done rises
//   Start      out  one-cycle pulse to the tester Run input
//   Busy       out  high from START through WAIT
//   Pass_LED   out  latched pass indication
//   Fail_LED   out  latched fail indication (also set on timeout)
//   Timeout    out  latched watchdog indication
//   Test_count out  completed runs, saturating at 255
//   Pass_count out  passing runs, saturating at 255
module chip_run_ctrl
  import chip_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run_btn,
  input  logic             Done,
  input  logic             RSLT,
  output logic             Start,
  output logic             Busy,
  output logic             Pass_LED,
  output logic             Fail_LED,
  output logic             Timeout,
  output logic [CNT_W-1:0] Test_count,
  output logic [CNT_W-1:0] Pass_count
);

  logic press;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (Clk),
    .rst    (Reset),
    .btn_raw(Run_btn),
    .press  (press)
  );

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  // Done and RSLT are registered together so the verdict lines up with the
  // detected edge; the edge is then taken between two registered samples.
  logic done_q, done_prev_q, rslt_q;
  logic done_edge;
  logic fire;

  assign done_edge = done_q & ~done_prev_q;

`ifdef CHIP_RUN_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  // Held at zero outside a run; counting already in START makes the
  // watchdog land exactly TIMEOUT_CYCLES cycles after the Start pulse.
  always_comb begin
    timer_d = '0;
    if (state_q == START || state_q == WAIT) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign fire = (state_q == WAIT) && (timer_q == TIMER_LAST);
`else
  // No watchdog in this build; TIMEOUT_CYCLES has no effect and this
  // expression is constant false.
  assign fire = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    tcnt_d  = tcnt_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (press) begin
          state_d = START;
          start_d = 1'b1;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      START: begin
        state_d = WAIT;
        busy_d  = 1'b1;
      end
      WAIT: begin
        // A Done edge takes priority over a watchdog firing in the same cycle.
        if (done_edge) begin
          state_d = DONE;
          busy_d  = 1'b0;
          pass_d  = rslt_q;
          fail_d  = ~rslt_q;
          tcnt_d  = sat_inc(tcnt_q);
          if (rslt_q) begin
            pcnt_d = sat_inc(pcnt_q);
          end
        end else if (fire) begin
          state_d = DONE;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
          fail_d  = 1'b1;
          tcnt_d  = sat_inc(tcnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      tmo_q       <= 1'b0;
      tcnt_q      <= '0;
      pcnt_q      <= '0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
      rslt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      tmo_q       <= tmo_d;
      tcnt_q      <= tcnt_d;
      pcnt_q      <= pcnt_d;
      done_q      <= Done;
      done_prev_q <= done_q;
      rslt_q      <= RSLT;
    end
  end

  assign Start      = start_q;
  assign Busy       = busy_q;
  assign Pass_LED   = pass_q;
  assign Fail_LED   = fail_q;
  assign Timeout    = tmo_q;
  assign Test_count = tcnt_q;
  assign Pass_count = pcnt_q;

endmodule

// File: tb/tb_chip_run_ctrl.sv
// Self-checking bench for chip_run_ctrl with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=20. Expected values come from cycle arithmetic on the
// documented latencies plus a tally model (saturating run/pass counts).
module tb_chip_run_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 20;

  logic       Clk = 1'b0;
  logic       Reset, Run_btn, Done, RSLT;
  logic       Start, Busy, Pass_LED, Fail_LED, Timeout;
  logic [7:0] Test_count, Pass_count;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int exp_tc = 0;
  int exp_pc = 0;
  int st0;

  chip_run_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run_btn   (Run_btn),
    .Done      (Done),
    .RSLT      (RSLT),
    .Start     (Start),
    .Busy      (Busy),
    .Pass_LED  (Pass_LED),
    .Fail_LED  (Fail_LED),
    .Timeout   (Timeout),
    .Test_count(Test_count),
    .Pass_count(Pass_count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: observed=expired required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (Start === 1'b1) starts++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic chk_result(input string tag, input bit p, input bit f, input bit t);
    chk({tag, "_pass"}, Pass_LED, p);
    chk({tag, "_fail"}, Fail_LED, f);
    chk({tag, "_tmo"},  Timeout, t);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_tc"},   Test_count, exp_tc);
    chk({tag, "_pc"},   Pass_count, exp_pc);
  endtask

  // Raises the button; Start must appear exactly DEB+3 cycles later with the
  // LEDs cleared. Returns at the Start cycle with the button still high.
  task automatic press_start(input string tag);
    Run_btn = 1'b1;
    tick_n(DEB + 2);
    chk({tag, "_prestart"}, Start, 0);
    tick();
    chk({tag, "_start"}, Start, 1);
    chk({tag, "_busy_start"}, Busy, 1);
    chk({tag, "_leds_clear"}, {Pass_LED, Fail_LED, Timeout}, 0);
  endtask

  // Full run: Done rises dly cycles after Start, result 2 cycles later.
  task automatic run(input string tag, input int dly, input bit rslt);
    press_start(tag);
    Run_btn = 1'b0;
    tick_n(dly);
    Done = 1'b1;
    RSLT = rslt;
    tick();
    chk({tag, "_busy_wait"}, Busy, 1);
    tick();
    Done = 1'b0;
    RSLT = 1'($urandom);
    exp_tc = sat(exp_tc);
    if (rslt) exp_pc = sat(exp_pc);
    chk_result(tag, rslt, !rslt, 0);
    tick_n(DEB + 4);
    chk({tag, "_held_pass"}, Pass_LED, rslt);
  endtask

  initial begin
    Reset = 1'b1; Run_btn = 1'b0; Done = 1'b0; RSLT = 1'b0;
    tick_n(3);
    chk("rst_start", Start, 0);
    chk_result("rst", 0, 0, 0);
    Reset = 1'b0;
    tick_n(3);

    // Glitch: 3 high cycles are short of the 4-sample debounce.
    st0 = starts;
    Run_btn = 1'b1;
    tick_n(3);
    Run_btn = 1'b0;
    tick_n(20);
    chk("glitch_starts", starts - st0, 0);
    chk("glitch_busy", Busy, 0);

    // 10-cycle press, Done with RSLT=1 five cycles after Start.
    st0 = starts;
    press_start("press10");
    tick_n(3);
    Run_btn = 1'b0;
    tick_n(2);
    Done = 1'b1; RSLT = 1'b1;
    tick();
    chk("press10_busy", Busy, 1);
    tick();
    Done = 1'b0;
    exp_tc = 1; exp_pc = 1;
    chk_result("passrun", 1, 0, 0);
    chk("press10_one_start", starts - st0, 1);
    tick_n(DEB + 4);

    // Randomized runs.
    for (int i = 0; i < 12; i++) run("rnd", $urandom_range(0, TMO - 2), 1'($urandom));

    // Second press during WAIT is discarded.
    st0 = starts;
    press_start("dropwait");
    Run_btn = 1'b0;
    tick_n(7);
    Run_btn = 1'b1;
    tick_n(7);
    Run_btn = 1'b0;
    tick();
    Done = 1'b1; RSLT = 1'b1;
    tick_n(2);
    Done = 1'b0;
    exp_tc = sat(exp_tc); exp_pc = sat(exp_pc);
    chk_result("dropwait", 1, 0, 0);
    chk("dropwait_starts", starts - st0, 1);
    tick_n(DEB + 6);

    // Stale Done: level already high, never an edge.
    Done = 1'b1; RSLT = 1'($urandom);
    tick_n(2);
    press_start("stale");
    Run_btn = 1'b0;
    tick_n(TMO - 1);
    chk("stale_pre_tmo", Timeout, 0);
    chk("stale_pre_busy", Busy, 1);
    tick();
`ifdef CHIP_RUN_CTRL_TIMEOUT_EN
    exp_tc = sat(exp_tc);
    chk_result("stale_tmo", 0, 1, 0 | 1);
    Done = 1'b0;
`else
    chk("stale_no_tmo", Timeout, 0);
    chk("stale_still_busy", Busy, 1);
    tick_n(10);
    chk("stale_still_busy2", Busy, 1);
    Done = 1'b0;
    tick();
    Done = 1'b1; RSLT = 1'b0;
    tick_n(2);
    Done = 1'b0;
    exp_tc = sat(exp_tc);
    chk_result("stale_late_done", 0, 1, 0);
`endif
    tick_n(DEB + 4);

    // Done edge detected in the very cycle the watchdog would fire.
    press_start("simul");
    Run_btn = 1'b0;
    tick_n(TMO - 2);
    Done = 1'b1; RSLT = 1'b0;
    tick();
    chk("simul_busy", Busy, 1);
    tick();
    Done = 1'b0;
    exp_tc = sat(exp_tc);
    chk_result("simul", 0, 1, 0);
    tick_n(DEB + 4);

    // Reset mid-WAIT with the button held through release.
    press_start("abort");
    tick_n(3);
    Reset = 1'b1;
    #1;
    exp_tc = 0; exp_pc = 0;
    chk("abort_start", Start, 0);
    chk_result("abort", 0, 0, 0);
    tick_n(2);
    Reset = 1'b0;
    tick_n(DEB + 2);
    chk("held_prestart", Start, 0);
    tick();
    chk("held_start", Start, 1);
    Run_btn = 1'b0;
    tick_n(2);
    Done = 1'b1; RSLT = 1'b1;
    tick_n(2);
    Done = 1'b0;
    exp_tc = 1; exp_pc = 1;
    chk_result("held", 1, 0, 0);
    tick_n(DEB + 4);

    // Saturation: more than 256 passing runs, then random verdicts.
    for (int i = 0; i < 258; i++) run("sat", $urandom_range(0, TMO - 2), 1'b1);
    chk("sat_tc", Test_count, 255);
    chk("sat_pc", Pass_count, 255);
    for (int i = 0; i < 3; i++) run("satrnd", $urandom_range(0, TMO - 2), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
